// File: rtl/ram_ctrl_pkg.sv
// Shared types and widths for the RAM command arbiter: command codes and FSM states.
package ram_ctrl_pkg;

    localparam int CMD_W  = 2;
    localparam int DATA_W = 8;

    typedef enum logic [CMD_W-1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } ram_cmd_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        DATA    = 3'd2,
        WAIT_RD = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/ram_cmd_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: one-hot pick from req plus the last winner.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] pick
);

    logic last_grant;

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last_grant ? 2'b01 : 2'b10;
        end
    end

    // Starts at 1 so requester 0 wins the first contention after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (upd && (pick != 2'b00)) begin
            last_grant <= pick[1];
        end
    end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Arbitrates two word-level requesters onto the RAM's two-phase 10-bit command port
// and returns read data (or a timeout error) to the owner.
module ram_cmd_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0,
    input  logic                    we0,
    input  logic [ADDR_SIZE-1:0]    addr0,
    input  logic [DATA_W-1:0]       wdata0,
    input  logic                    req1,
    input  logic                    we1,
    input  logic [ADDR_SIZE-1:0]    addr1,
    input  logic [DATA_W-1:0]       wdata1,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    done0,
    output logic                    done1,
    output logic [DATA_W-1:0]       rdata,
    output logic                    err,
    output logic                    busy,
    output logic [CMD_W+DATA_W-1:0] ram_din,
    output logic                    ram_rx_valid,
    input  logic [DATA_W-1:0]       ram_dout,
    input  logic                    ram_tx_valid
);

    state_e                 state;
    logic                   owner_q;
    logic                   we_q;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [3:0]             cnt;

    logic [1:0]             pick;
    logic                   grant_en;
    logic                   sel_we;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [DATA_W-1:0]      sel_wdata;

    assign grant_en  = (state == IDLE) && (req0 || req1);
    assign sel_we    = pick[1] ? we1    : we0;
    assign sel_addr  = pick[1] ? addr1  : addr0;
    assign sel_wdata = pick[1] ? wdata1 : wdata0;

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1, req0}),
        .upd   (grant_en),
        .pick  (pick)
    );

    // Outputs are loaded with the values of the state being entered, so the
    // address phase appears on the same edge that issues the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt          <= '0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            rdata        <= '0;
            err          <= 1'b0;
            busy         <= 1'b0;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        owner_q      <= pick[1];
                        we_q         <= sel_we;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        gnt0         <= pick[0];
                        gnt1         <= pick[1];
                        busy         <= 1'b1;
                        ram_rx_valid <= 1'b1;
                        ram_din      <= {(sel_we ? WR_ADDR : RD_ADDR), sel_addr};
                        state        <= ADDR;
                    end
                end
                ADDR: begin
                    ram_din <= we_q ? {WR_DATA, wdata_q} : {RD_DATA, 8'h00};
                    state   <= DATA;
                end
                DATA: begin
                    ram_rx_valid <= 1'b0;
                    ram_din      <= '0;
                    cnt          <= '0;
                    if (we_q) begin
                        done0 <= ~owner_q;
                        done1 <= owner_q;
                        err   <= 1'b0;
                        state <= DONE;
                    end else begin
                        state <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (ram_tx_valid) begin
                        rdata <= ram_dout;
                        err   <= 1'b0;
                        done0 <= ~owner_q;
                        done1 <= owner_q;
                        state <= DONE;
                    end else if (cnt == 4'(TIMEOUT - 1)) begin
                        rdata <= 8'h00;
                        err   <= 1'b1;
                        done0 <= ~owner_q;
                        done1 <= owner_q;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic unused_addr_q;
    assign unused_addr_q = ^addr_q;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Self-checking bench for ram_cmd_arbiter: vector table, corner sequences, randomized run.
module tb_ram_cmd_arbiter;

    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
    logic       gnt0, gnt1, done0, done1, err, busy, ram_rx_valid;
    logic [7:0] rdata;
    logic [9:0] ram_din;
    logic [7:0] ram_dout = 0;
    logic       ram_tx_valid = 0;

    int n_pass = 0;
    int n_total = 0;
    int model_last = 1;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } rq_t;

    typedef struct {
        logic [1:0] req;
        rq_t        r0;
        rq_t        r1;
        int         delay;
        logic [7:0] dout;
        logic       drop;
        int         exp_who;
        logic [9:0] exp_a;
        logic [9:0] exp_d;
        int         exp_lat;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    ram_cmd_arbiter #(.ADDR_SIZE(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err), .busy(busy),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] all_outs();
        return {7'd0, gnt0, gnt1, done0, done1, rdata, err, busy, ram_din, ram_rx_valid};
    endfunction

    function automatic rq_t mkrq(input logic we, input logic [7:0] a, input logic [7:0] d);
        rq_t r;
        r.we = we; r.addr = a; r.wdata = d;
        return r;
    endfunction

    function automatic vec_t mkv(input logic [1:0] req, input rq_t r0, input rq_t r1,
                                 input int delay, input logic [7:0] dout, input logic drop,
                                 input int who, input logic [9:0] ea, input logic [9:0] ed,
                                 input int lat, input logic [7:0] rd, input logic er);
        vec_t v;
        v.req = req; v.r0 = r0; v.r1 = r1; v.delay = delay; v.dout = dout; v.drop = drop;
        v.exp_who = who; v.exp_a = ea; v.exp_d = ed; v.exp_lat = lat;
        v.exp_rdata = rd; v.exp_err = er;
        return v;
    endfunction

    // Reference model: word-level rules for who wins and what the RAM should see.
    function automatic vec_t model(input vec_t v);
        vec_t o = v;
        rq_t  rq;
        if (v.req == 2'b11) o.exp_who = (model_last == 1) ? 0 : 1;
        else                o.exp_who = v.req[1] ? 1 : 0;
        rq = (o.exp_who == 1) ? v.r1 : v.r0;
        o.exp_a = {(rq.we ? 2'd0 : 2'd2), rq.addr};
        o.exp_d = rq.we ? {2'd1, rq.wdata} : {2'd3, 8'h00};
        if (rq.we) begin
            o.exp_lat = 2; o.exp_rdata = 8'h00; o.exp_err = 1'b0;
        end else if (v.delay >= 0 && v.delay < TIMEOUT) begin
            o.exp_lat = 3 + v.delay; o.exp_rdata = v.dout; o.exp_err = 1'b0;
        end else begin
            o.exp_lat = 2 + TIMEOUT; o.exp_rdata = 8'h00; o.exp_err = 1'b1;
        end
        return o;
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        int   lat;
        logic seen;
        logic wr;
        logic [1:0] oh;
        oh = (v.exp_who == 1) ? 2'b10 : 2'b01;
        wr = (v.exp_who == 1) ? v.r1.we : v.r0.we;
        req0 = v.req[0]; we0 = v.r0.we; addr0 = v.r0.addr; wdata0 = v.r0.wdata;
        req1 = v.req[1]; we1 = v.r1.we; addr1 = v.r1.addr; wdata1 = v.r1.wdata;
        @(posedge clk); #1;
        chk({nm, " grant"}, {30'd0, gnt1, gnt0}, {30'd0, oh});
        chk({nm, " addr_phase"}, {20'd0, busy, ram_rx_valid, ram_din}, {20'd0, 2'b11, v.exp_a});
        addr0 = ~addr0; wdata0 = ~wdata0; we0 = ~we0;
        addr1 = ~addr1; wdata1 = ~wdata1; we1 = ~we1;
        if (v.drop) begin req0 = 0; req1 = 0; end
        @(posedge clk); #1;
        chk({nm, " data_phase"}, {21'd0, ram_rx_valid, ram_din}, {21'd0, 1'b1, v.exp_d});
        lat = 1; seen = 0;
        while (!seen && lat < 20) begin
            ram_tx_valid = (v.delay >= 0 && lat == 2 + v.delay);
            ram_dout = ram_tx_valid ? v.dout : 8'($urandom);
            @(posedge clk); #1;
            lat++;
            seen = done0 | done1;
        end
        ram_tx_valid = 0;
        chk({nm, " done_seen"}, {31'd0, seen}, 32'd1);
        chk({nm, " latency"}, lat, v.exp_lat);
        chk({nm, " done_owner"}, {28'd0, done1, done0, gnt1, gnt0}, {28'd0, oh, oh});
        chk({nm, " err_rx"}, {30'd0, err, ram_rx_valid}, {30'd0, v.exp_err, 1'b0});
        if (!wr) chk({nm, " rdata"}, {24'd0, rdata}, {24'd0, v.exp_rdata});
        req0 = 0; req1 = 0;
        @(posedge clk); #1;
        chk({nm, " back_idle"}, {25'd0, busy, gnt1, gnt0, done1, done0, err, ram_rx_valid}, 32'd0);
        model_last = v.exp_who;
    endtask

    vec_t tbl[8];
    vec_t rv;
    int   order[$];
    logic p0, p1;

    initial begin
        tbl[0] = mkv(2'b01, mkrq(1, 8'h3C, 8'h5A), mkrq(0, 8'h00, 8'h00), -1, 8'h00, 0,
                     0, 10'h03C, 10'h15A, 2, 8'h00, 0);
        tbl[1] = mkv(2'b10, mkrq(1, 8'h11, 8'h22), mkrq(0, 8'h3C, 8'h00), 0, 8'h5A, 0,
                     1, 10'h23C, 10'h300, 3, 8'h5A, 0);
        tbl[2] = mkv(2'b11, mkrq(1, 8'h01, 8'hFF), mkrq(1, 8'h02, 8'hEE), -1, 8'h00, 0,
                     0, 10'h001, 10'h1FF, 2, 8'h00, 0);
        tbl[3] = mkv(2'b11, mkrq(1, 8'h03, 8'h44), mkrq(0, 8'hFF, 8'h00), 2, 8'hA5, 0,
                     1, 10'h2FF, 10'h300, 5, 8'hA5, 0);
        tbl[4] = mkv(2'b11, mkrq(0, 8'h80, 8'h00), mkrq(1, 8'h04, 8'h55), -1, 8'h00, 0,
                     0, 10'h280, 10'h300, 6, 8'h00, 1);
        tbl[5] = mkv(2'b11, mkrq(1, 8'h05, 8'h66), mkrq(0, 8'h10, 8'h00), 3, 8'h77, 0,
                     1, 10'h210, 10'h300, 6, 8'h77, 0);
        tbl[6] = mkv(2'b10, mkrq(0, 8'h00, 8'h00), mkrq(1, 8'h00, 8'h00), -1, 8'h00, 0,
                     1, 10'h000, 10'h100, 2, 8'h00, 0);
        tbl[7] = mkv(2'b01, mkrq(0, 8'h42, 8'h00), mkrq(0, 8'h00, 8'h00), 1, 8'hC3, 1,
                     0, 10'h242, 10'h300, 4, 8'hC3, 0);

        // Reset state
        #2 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", all_outs(), 32'd0);
        rst_n = 1;
        @(posedge clk); #1;
        chk("post_reset_idle", all_outs(), 32'd0);
        model_last = 1;

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Spurious tx_valid while idle must not start anything
        for (int i = 0; i < 3; i++) begin
            ram_tx_valid = 1; ram_dout = 8'h99;
            @(posedge clk); #1;
            chk("spurious_tx", {27'd0, busy, gnt1, gnt0, done1 | done0, ram_rx_valid}, 32'd0);
        end
        ram_tx_valid = 0;

        // Both requests held continuously from reset: grants must alternate
        rst_n = 0; #3 rst_n = 1;
        @(posedge clk); #1;
        model_last = 1;
        req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 8'h01;
        req1 = 1; we1 = 1; addr1 = 8'h30; wdata1 = 8'h02;
        p0 = 0; p1 = 0;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(posedge clk); #1;
            if (gnt0 && gnt1) chk("gnt_exclusive", {30'd0, gnt1, gnt0}, 32'd0);
            if (gnt0 && !p0) order.push_back(0);
            if (gnt1 && !p1) order.push_back(1);
            p0 = gnt0; p1 = gnt1;
        end
        req0 = 0; req1 = 0;
        chk("contention_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) chk($sformatf("contention_order%0d", i), order[i], i % 2);
        for (int c = 0; c < 10 && busy; c++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        chk("contention_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset during the data phase
        req0 = 1; we0 = 1; addr0 = 8'h55; wdata0 = 8'hAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_data_phase", {22'd0, ram_din}, {22'd0, 10'h1AA});
        #2 rst_n = 0;
        #1 chk("async_reset_outputs", all_outs(), 32'd0);
        req0 = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        chk("after_reset_idle", all_outs(), 32'd0);
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        @(posedge clk); #1;
        chk("after_reset_first_grant", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 0; req1 = 0;
        for (int c = 0; c < 10 && busy; c++) begin @(posedge clk); #1; end
        chk("after_reset_done", {31'd0, busy}, 32'd0);
        model_last = 0;

        // Randomized transactions against the reference model
        for (int i = 0; i < 30; i++) begin
            rv.req  = 2'($urandom_range(1, 3));
            rv.r0   = mkrq(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            rv.r1   = mkrq(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            rv.delay = int'($urandom_range(0, 4));
            if (rv.delay == 4) rv.delay = -1;
            rv.dout = 8'($urandom);
            rv.drop = 1'($urandom_range(0, 1));
            rv = model(rv);
            run_vec(rv, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
